// File: rtl/ecpu_rom_arb.sv
// ecpu_rom_arb -- arbitrates one single-port ROM RAM between the ioctl
// download path (writes) and a CPU read port.
//
// Download writes that fall inside the window [BASE, BASE+SIZE) are staged
// in a one-entry holding register and committed to the RAM in a one-cycle
// WRITE state. Writes always win over CPU reads. CPU reads take three cycles
// from the sampled request to the one-cycle ack pulse (IDLE -> READ -> DATA,
// then ack). Each read ends back in IDLE, so two acks can never be adjacent.
//
// Optional feature: define ECPU_ROM_ARB_CKSUM_EN to add a 16-bit running sum
// of every byte committed to the RAM. The sum clears at reset and at the
// start of each download.
//
// Ports:
//   clk_sys         system clock, rising edge
//   rst_n           asynchronous active-low reset
//   ioctl_download  download in progress
//   ioctl_addr      download byte address (27 bits)
//   ioctl_dout      download data, low byte used
//   ioctl_wr        one-cycle download write strobe
//   cpu_req         CPU read request, held until cpu_ack
//   cpu_addr        CPU read address
//   cpu_ack         one-cycle read completion pulse
//   cpu_data        read data, held until the next ack
//   rom_addr        RAM address (follows cpu_addr while idle)
//   rom_din         RAM write data (0 outside WRITE)
//   rom_wr_n        RAM write enable, active low
//   rom_q           RAM read data, one cycle after rom_addr
//   busy            FSM is not idle
//   done            sticky, set when a download ends
//   ovf             sticky, the holding register was overwritten
//   cksum           (ECPU_ROM_ARB_CKSUM_EN only) sum of committed bytes
module ecpu_rom_arb #(
  parameter int          AW   = 14,
  parameter logic [26:0] BASE = 27'h29000,
  parameter logic [26:0] SIZE = 27'h4000
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          ioctl_download,
  input  logic [26:0]   ioctl_addr,
  input  logic [15:0]   ioctl_dout,
  input  logic          ioctl_wr,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_data,
  output logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_din,
  output logic          rom_wr_n,
  input  logic [7:0]    rom_q,
  output logic          busy,
  output logic          done,
  output logic          ovf
`ifdef ECPU_ROM_ARB_CKSUM_EN
  ,
  output logic [15:0]   cksum
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DATA  = 2'd3;

  // One extra bit so BASE+SIZE cannot wrap at the top of the address space.
  localparam logic [27:0] WIN_LO = {1'b0, BASE};
  localparam logic [27:0] WIN_HI = {1'b0, BASE} + {1'b0, SIZE};

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic          pending_r;
  logic [AW-1:0] hold_addr_r;
  logic [7:0]    hold_data_r;
  logic [AW-1:0] rom_addr_r;
  logic [7:0]    rom_din_r;
  logic          rom_wr_n_r;
  logic          cpu_ack_r;
  logic [7:0]    cpu_data_r;
  logic          busy_r;
  logic          done_r;
  logic          ovf_r;
  logic          dl_q_r;

  logic          in_win_s;
  logic          accept_s;
  logic          ovf_set_s;
  logic          dl_rise_s;
  logic          dl_fall_s;
  logic [26:0]   off_full_s;
  logic [AW-1:0] offset_s;
  logic          unused_dout_s;

  assign in_win_s      = ({1'b0, ioctl_addr} >= WIN_LO) && ({1'b0, ioctl_addr} < WIN_HI);
  assign accept_s      = ioctl_wr && ioctl_download && in_win_s;
  assign off_full_s    = ioctl_addr - BASE;
  assign offset_s      = off_full_s[AW-1:0];
  assign dl_rise_s     = ioctl_download && !dl_q_r;
  assign dl_fall_s     = !ioctl_download && dl_q_r;
  // A new byte arriving while the staged one is still waiting loses the old
  // one; during WRITE the staged byte is already on its way to the RAM.
  assign ovf_set_s     = accept_s && pending_r && (state_r != ST_WRITE);
  assign unused_dout_s = ^ioctl_dout[15:8];

  // Next-state selection: pending write first, then a CPU read when no
  // download is running.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pending_r) begin
          state_nxt_s = ST_WRITE;
        end else if (cpu_req && !ioctl_download) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: state_nxt_s = ST_IDLE;
      ST_READ:  state_nxt_s = ST_DATA;
      ST_DATA:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state plus registered RAM-side and CPU-side outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      rom_wr_n_r <= 1'b1;
      rom_addr_r <= {AW{1'b0}};
      rom_din_r  <= 8'h00;
      cpu_ack_r  <= 1'b0;
      cpu_data_r <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      rom_wr_n_r <= (state_nxt_s != ST_WRITE);
      // Snapshot the staged entry on entry to WRITE so a new download byte
      // landing in the holding register cannot corrupt the write in flight.
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_WRITE)) begin
        rom_addr_r <= hold_addr_r;
        rom_din_r  <= hold_data_r;
      end else begin
        if ((state_r == ST_IDLE) && (state_nxt_s == ST_READ)) begin
          rom_addr_r <= cpu_addr;
        end
        rom_din_r <= 8'h00;
      end
      cpu_ack_r <= (state_r == ST_DATA);
      if (state_r == ST_DATA) begin
        cpu_data_r <= rom_q;
      end
    end
  end

  // Holding register and its pending flag.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pending_r   <= 1'b0;
      hold_addr_r <= {AW{1'b0}};
      hold_data_r <= 8'h00;
    end else begin
      if (accept_s) begin
        pending_r   <= 1'b1;
        hold_addr_r <= offset_s;
        hold_data_r <= ioctl_dout[7:0];
      end else if (state_r == ST_WRITE) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Download edge detection and the sticky done/ovf flags.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dl_q_r <= 1'b0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      dl_q_r <= ioctl_download;
      if (dl_fall_s) begin
        done_r <= 1'b1;
      end else if (dl_rise_s) begin
        done_r <= 1'b0;
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (dl_rise_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

`ifdef ECPU_ROM_ARB_CKSUM_EN
  logic [15:0] cksum_r;

  // Running sum of bytes actually committed to the RAM.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cksum_r <= 16'h0000;
    end else if (dl_rise_s) begin
      cksum_r <= 16'h0000;
    end else if (state_r == ST_WRITE) begin
      cksum_r <= cksum_r + {8'h00, rom_din_r};
    end
  end

  assign cksum = cksum_r;
`endif

  // While idle the RAM address tracks the CPU so the read path needs no
  // extra setup cycle; elsewhere it shows the captured operation address.
  assign rom_addr = (state_r == ST_IDLE) ? cpu_addr : rom_addr_r;
  assign rom_din  = rom_din_r;
  assign rom_wr_n = rom_wr_n_r;
  assign cpu_ack  = cpu_ack_r;
  assign cpu_data = cpu_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_ecpu_rom_arb.sv
// Self-checking bench for ecpu_rom_arb: directed boundary cases followed by
// randomized download and read traffic checked against a byte-level memory
// model of what the downloads should have left in the ROM.
module tb_ecpu_rom_arb;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        ioctl_download;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wr;
  logic        cpu_req;
  logic [13:0] cpu_addr;
  logic        cpu_ack;
  logic [7:0]  cpu_data;
  logic [13:0] rom_addr;
  logic [7:0]  rom_din;
  logic        rom_wr_n;
  logic [7:0]  rom_q;
  logic        busy;
  logic        done;
  logic        ovf;
`ifdef ECPU_ROM_ARB_CKSUM_EN
  logic [15:0] cksum;
`endif

  ecpu_rom_arb dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .ioctl_download (ioctl_download),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_ack        (cpu_ack),
    .cpu_data       (cpu_data),
    .rom_addr       (rom_addr),
    .rom_din        (rom_din),
    .rom_wr_n       (rom_wr_n),
    .rom_q          (rom_q),
    .busy           (busy),
    .done           (done),
    .ovf            (ovf)
`ifdef ECPU_ROM_ARB_CKSUM_EN
    ,
    .cksum          (cksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous RAM attached to the ROM port.
  logic [7:0] ram [0:16383];
  always @(posedge clk_sys) begin
    if (!rom_wr_n) ram[rom_addr] <= rom_din;
    rom_q <= ram[rom_addr];
  end

  // Event counters sampled mid-cycle.
  int ack_cnt = 0;
  int wr_cnt  = 0;
  always @(negedge clk_sys) begin
    if (cpu_ack === 1'b1) ack_cnt++;
    if (rom_wr_n === 1'b0) wr_cnt++;
  end

  // Reference model: expected ROM image from accepted download bytes.
  logic [7:0]  ref_mem [0:16383];
  bit          known   [0:16383];
  logic [13:0] known_q [$];
  logic [15:0] exp_sum;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic bit in_window(input logic [26:0] a);
    return (a >= 27'h29000) && (a < 27'h2D000);
  endfunction

  // Record what a download write should do, assuming no overrun.
  task automatic model_wr(input logic [26:0] a, input logic [7:0] d);
    logic [26:0] off;
    if (ioctl_download && in_window(a)) begin
      off = a - 27'h29000;
      ref_mem[off[13:0]] = d;
      if (!known[off[13:0]]) known_q.push_back(off[13:0]);
      known[off[13:0]] = 1'b1;
      exp_sum = exp_sum + {8'h00, d};
    end
  endtask

  task automatic drive_wr(input logic [26:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic do_write(input logic [26:0] a, input logic [15:0] d);
    model_wr(a, d[7:0]);
    drive_wr(a, d);
  endtask

  task automatic do_read(input logic [13:0] a);
    int  lat;
    bit  got;
    logic [7:0] exp;
    exp      = ref_mem[a];
    cpu_addr = a;
    cpu_req  = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (cpu_ack === 1'b1) got = 1'b1;
    end
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", 32'(cpu_data), 32'(exp));
    cpu_req = 1'b0;
    tick();
    chk("rd_ack_single", 32'(cpu_ack), 32'd0);
    chk("rd_data_hold", 32'(cpu_data), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0;
    int          a0;
    int          n_in;
    int          bad;
    logic [26:0] a;
    logic [13:0] ra;

    for (int i = 0; i < 16384; i++) begin
      known[i]   = 1'b0;
      ref_mem[i] = 8'h00;
    end
    exp_sum        = 16'h0000;
    rst_n          = 1'b0;
    ioctl_download = 1'b0;
    ioctl_addr     = 27'h0;
    ioctl_dout     = 16'h0;
    ioctl_wr       = 1'b0;
    cpu_req        = 1'b0;
    cpu_addr       = 14'h1555;
    ticks(3);
    rst_n = 1'b1;
    tick();

    // Reset state.
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_data", 32'(cpu_data), 32'h00);
    chk("rst_wr_n", 32'(rom_wr_n), 32'd1);
    chk("idle_din", 32'(rom_din), 32'h00);
    chk("idle_addr", 32'(rom_addr), 32'h1555);

    // First window byte: one-cycle write at offset 0.
    ioctl_download = 1'b1;
    tick();
    exp_sum = 16'h0000;
    do_write(27'h29000, 16'h00A5);
    chk("w0_staged_wr_n", 32'(rom_wr_n), 32'd1);
    tick();
    chk("w0_wr_n", 32'(rom_wr_n), 32'd0);
    chk("w0_addr", 32'(rom_addr), 32'h0000);
    chk("w0_din", 32'(rom_din), 32'hA5);
    tick();
    chk("w0_end_wr_n", 32'(rom_wr_n), 32'd1);
    chk("w0_end_din", 32'(rom_din), 32'h00);

    // Just outside both ends of the window.
    w0 = wr_cnt;
    drive_wr(27'h2D000, 16'h0011);
    ticks(2);
    drive_wr(27'h28FFF, 16'h0022);
    ticks(3);
    chk("outside_writes", 32'(wr_cnt - w0), 32'd0);
    chk("outside_ovf", 32'(ovf), 32'd0);

    // CPU requests are ignored during a download.
    cpu_addr = 14'h0005;
    cpu_req  = 1'b1;
    a0 = ack_cnt;
    ticks(6);
    chk("dl_req_ack", 32'(ack_cnt - a0), 32'd0);
    chk("dl_req_busy", 32'(busy), 32'd0);
    cpu_req = 1'b0;

    do_write(27'h29123, 16'hFF5C);
    ticks(3);
`ifdef ECPU_ROM_ARB_CKSUM_EN
    chk("cksum_dl1", 32'(cksum), 32'(exp_sum));
`endif
    ioctl_download = 1'b0;
    tick();
    chk("done_set", 32'(done), 32'd1);

    // Read of the byte just downloaded.
    do_read(14'h0123);
    chk("read_5c", 32'(ref_mem[14'h0123]), 32'h5C);

    // Overrun while a read is in flight.
    cpu_addr = 14'h0123;
    cpu_req  = 1'b1;
    tick();
    chk("ovr_busy", 32'(busy), 32'd1);
    ioctl_download = 1'b1;
    w0 = wr_cnt;
    drive_wr(27'h29010, 16'h0011);
    drive_wr(27'h29020, 16'h0022);
    chk("ovr_ack", 32'(cpu_ack), 32'd1);
    chk("ovr_data", 32'(cpu_data), 32'h5C);
    cpu_req = 1'b0;
    ref_mem[14'h0020] = 8'h22;
    if (!known[14'h0020]) known_q.push_back(14'h0020);
    known[14'h0020] = 1'b1;
    ticks(3);
    chk("ovr_flag", 32'(ovf), 32'd1);
    chk("ovr_writes", 32'(wr_cnt - w0), 32'd1);
    chk("ovr_ram", 32'(ram[14'h0020]), 32'h22);
`ifdef ECPU_ROM_ARB_CKSUM_EN
    chk("ovr_cksum", 32'(cksum), 32'h0022);
`endif
    ioctl_download = 1'b0;
    tick();
    chk("ovr_done", 32'(done), 32'd1);
    chk("ovr_sticky", 32'(ovf), 32'd1);

    // Randomized download.
    ioctl_download = 1'b1;
    tick();
    chk("rise_clr_ovf", 32'(ovf), 32'd0);
    chk("rise_clr_done", 32'(done), 32'd0);
    exp_sum = 16'h0000;
    w0   = wr_cnt;
    n_in = 0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 27'h29000 - 27'(1 + $urandom_range(0, 300));
        1:       a = 27'h2D000 + 27'($urandom_range(0, 300));
        default: a = 27'h29000 + 27'($urandom_range(0, 16383));
      endcase
      if (in_window(a)) n_in++;
      do_write(a, 16'($urandom));
      ticks($urandom_range(2, 4));
    end
    ticks(3);
    chk("rnd_writes", 32'(wr_cnt - w0), 32'(n_in));
    chk("rnd_ovf", 32'(ovf), 32'd0);
`ifdef ECPU_ROM_ARB_CKSUM_EN
    chk("rnd_cksum", 32'(cksum), 32'(exp_sum));
`endif
    ioctl_download = 1'b0;
    tick();
    chk("rnd_done", 32'(done), 32'd1);

    // Window writes with download low are ignored.
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      do_write(27'h29000 + 27'($urandom_range(0, 16383)), 16'($urandom));
      ticks(2);
    end
    chk("nodl_writes", 32'(wr_cnt - w0), 32'd0);

    bad = 0;
    for (int i = 0; i < 16384; i++) begin
      if (known[i] && (ram[i] !== ref_mem[i])) bad++;
    end
    chk("mem_image", 32'(bad), 32'd0);

    // Randomized reads of downloaded bytes.
    for (int i = 0; i < 40; i++) begin
      ra = known_q[$urandom_range(0, known_q.size() - 1)];
      do_read(ra);
      ticks($urandom_range(0, 2));
    end

    // Reset in the middle of a read.
    cpu_addr = known_q[0];
    cpu_req  = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(cpu_ack), 32'd0);
    chk("mid_rst_data", 32'(cpu_data), 32'h00);
    chk("mid_rst_wr_n", 32'(rom_wr_n), 32'd1);
    chk("mid_rst_din", 32'(rom_din), 32'h00);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
`ifdef ECPU_ROM_ARB_CKSUM_EN
    chk("mid_rst_cksum", 32'(cksum), 32'h0000);
`endif
    cpu_req = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    a0 = ack_cnt;
    ticks(6);
    chk("post_rst_ack", 32'(ack_cnt - a0), 32'd0);

    // Checksum of two bytes with carry into the upper byte.
    ioctl_download = 1'b1;
    tick();
    exp_sum = 16'h0000;
    do_write(27'h29100, 16'h00FF);
    ticks(3);
    do_write(27'h29101, 16'h0002);
    ticks(3);
`ifdef ECPU_ROM_ARB_CKSUM_EN
    chk("cksum_0101", 32'(cksum), 32'h0101);
`endif
    ioctl_download = 1'b0;
    tick();
    do_read(14'h0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
